// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues word reads to imem, buffers returns in an in-order prefetch FIFO for decode.
// Latency: a request accepted in cycle N whose response arrives in N+1 is presented to decode in N+2.
// Backpressure: requests are credit-limited (outstanding + buffered <= FIFO_DEPTH), so a stalled decode stops fetching.
module instr_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [31:0]           imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_STEP     = ADDR_WIDTH'(4);
    localparam logic [CW:0]           DEPTH_LIMIT = (CW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         ONE         = CW'(1);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           data;
    } fetch_entry_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    // PC of the next response to be buffered. Fetches are sequential and
    // return in order, so this running counter stands in for a tag queue.
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
    fetch_entry_t          fifo_mem [FIFO_DEPTH];

    fetch_entry_t          head;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         pending;
    logic [CW:0]           credit_used;
    logic                  fifo_empty;
    logic                  req_xfer;
    logic                  consume;
    logic                  rsp_hit;
    logic                  push;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  unused_redirect_lsbs;

    // Occupancy, credit check and the handshake qualifiers.
    always_comb begin
        fifo_count      = wr_ptr_q - rd_ptr_q;
        fifo_empty      = (fifo_count == '0);
        credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count};
        // Reset gates the request so it is low for the whole reset window.
        imem_req_valid  = !reset && (state_q == RUN) && !redirect_valid
                          && (credit_used < DEPTH_LIMIT);
        imem_req_addr   = pc_q;
        req_xfer        = imem_req_valid && imem_req_ready;
        head            = fifo_mem[rd_ptr_q[PW-1:0]];
        instr_valid     = !fifo_empty;
        instruction     = fifo_empty ? 32'h0 : head.data;
        instr_pc        = fifo_empty ? '0 : head.pc;
        consume         = instr_valid && instr_ready;
        // Only one of outstanding/drop_cnt is ever non-zero (RUN vs FLUSH).
        pending         = outstanding_q + drop_cnt_q;
        // A response with nothing pending is stray and is ignored entirely.
        rsp_hit         = imem_rsp_valid && (pending != '0);
        push            = rsp_hit && (state_q == RUN) && !redirect_valid;
        redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        unused_redirect_lsbs = ^redirect_pc[1:0];
    end

    // Next-state: redirect overrides everything, otherwise fetch (RUN) or drain stale responses (FLUSH).
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        if (redirect_valid) begin
            pc_d          = redirect_target;
            rsp_pc_d      = redirect_target;
            outstanding_d = '0;
            // A response landing in the redirect cycle is already accounted for.
            drop_cnt_d    = pending - CW'(rsp_hit);
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            state_d       = (drop_cnt_d != '0) ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (req_xfer) begin
                        pc_d = pc_q + PC_STEP;
                    end
                    outstanding_d = outstanding_q + CW'(req_xfer) - CW'(push);
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + ONE;
                        rsp_pc_d = rsp_pc_q + PC_STEP;
                    end
                    if (consume) begin
                        rd_ptr_d = rd_ptr_q + ONE;
                    end
                end
                FLUSH: begin
                    if (rsp_hit) begin
                        drop_cnt_d = drop_cnt_q - ONE;
                        if (drop_cnt_q == ONE) begin
                            state_d = RUN;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Control state; asynchronous reset returns to an empty RUN state at RESET_PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Prefetch storage; entries are only observed while valid, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PW-1:0]] <= '{pc: rsp_pc_q, data: imem_rsp_data};
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with programmable latency and request grants.
// Scoreboard of expected {pc, word} pairs is checked on every decode consume.
// All inputs change 1ns after the rising edge; outputs are sampled mid-cycle.
module tb_instr_fetch;
    localparam int AW    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_req_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [31:0]   imem_rsp_data = 32'h0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instruction;
    logic [AW-1:0] instr_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   mem_lat = 1;
    int   mem_grant = 0;
    int   acc_cnt = 0;
    int   acc_base = 0;
    int   cons_first = -1;
    int   cons_last = -1;
    bit   ok;
    exp_t exp_q[$];
    rsp_t rsp_q[$];

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return 32'h2022_0005 ^ (a * 32'h0100_0193);
    endfunction

    task automatic expect_pc(input logic [AW-1:0] a);
        exp_q.push_back('{pc: a, data: mem_word(a)});
    endtask

    task automatic grant(input int n);
        mem_grant      = acc_cnt + n;
        imem_req_ready = (acc_cnt < mem_grant);
    endtask

    // One clock: sample consumes/requests at the falling edge, then drive memory for the next cycle.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (instr_valid && instr_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: pc=%h word=%h delivered, none expected", instr_pc, instruction);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instruction !== e.data) begin
                    miscompares++;
                    $display("FAIL sb_instr: got pc=%h word=%h, expected pc=%h word=%h",
                             instr_pc, instruction, e.pc, e.data);
                end
            end
            if (cons_first < 0) cons_first = cyc;
            cons_last = cyc;
        end
        if (imem_req_valid && imem_req_ready) begin
            rsp_q.push_back('{due: cyc + mem_lat, data: mem_word(imem_req_addr)});
            acc_cnt++;
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_req_ready = (acc_cnt < mem_grant);
        if (rsp_q.size() != 0 && rsp_q[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic drain(input int bound, output bit done);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
        done = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        tick();
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b need 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid: got %b need 0", instr_valid); end
        vectors++; if (instruction !== 32'h0) begin miscompares++; $display("FAIL rst_instruction: got %h need 0", instruction); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL rst_instr_pc: got %h need 0", instr_pc); end
        tick();
        reset = 1'b0;
        #2;
        vectors++; if (imem_req_valid !== 1'b1) begin miscompares++; $display("FAIL first_req_valid: got %b need 1", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h0) begin miscompares++; $display("FAIL first_req_addr: got %h need 0", imem_req_addr); end
    endtask

    task automatic test_backpressure();
        mem_lat     = 1;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) expect_pc(AW'(4 * i));
        acc_base = acc_cnt;
        grant(100);
        repeat (10) tick();
        #2;
        vectors++; if (acc_cnt - acc_base !== 4) begin miscompares++; $display("FAIL bp_req_count: got %0d need 4", acc_cnt - acc_base); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL bp_req_valid: got %b need 0", imem_req_valid); end
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL bp_instr_valid: got %b need 1", instr_valid); end
        vectors++; if (instr_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head_pc: got %h need 0", instr_pc); end
        vectors++; if (instruction !== 32'h2022_0005) begin miscompares++; $display("FAIL bp_head_word: got %h need 20220005", instruction); end
        for (int i = 4; i < 8; i++) expect_pc(AW'(4 * i));
        grant(4);
        instr_ready = 1'b1;
        drain(60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_drain: %0d entries left, need 0", exp_q.size()); end
        vectors++; if (acc_cnt - acc_base !== 8) begin miscompares++; $display("FAIL bp_total_reqs: got %0d need 8", acc_cnt - acc_base); end
    endtask

    task automatic test_back_to_back();
        mem_lat     = 1;
        instr_ready = 1'b1;
        for (int i = 0; i < 12; i++) expect_pc(AW'(32'h20 + 4 * i));
        cons_first = -1;
        cons_last  = -1;
        grant(12);
        drain(80, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_drain: %0d entries left, need 0", exp_q.size()); end
        vectors++; if (cons_last - cons_first !== 11) begin miscompares++; $display("FAIL b2b_throughput: 12 instrs over %0d cycles, need 11", cons_last - cons_first); end
    endtask

    task automatic test_stall();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8;
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL stall_redirect_req: got %b need 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        for (int i = 0; i < 3; i++) begin
            #2;
            vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin
                miscompares++; $display("FAIL stall_hold: cycle %0d valid=%b addr=%h, need 1/00000008", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        expect_pc(32'h8);
        grant(1);
        tick();
        #2;
        vectors++; if (imem_req_addr !== 32'hC) begin miscompares++; $display("FAIL stall_next_pc: got %h need 0000000c", imem_req_addr); end
        drain(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL stall_drain: %0d entries left, need 0", exp_q.size()); end
    endtask

    task automatic test_redirect();
        mem_lat     = 3;
        instr_ready = 1'b1;
        grant(3);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_cycle_req: got %b need 0", imem_req_valid); end
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_req: got %b need 0", imem_req_valid); end
        vectors++; if (imem_req_addr !== 32'h100) begin miscompares++; $display("FAIL redir_target: got %h need 00000100", imem_req_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_flush_instr0: got %b need 0", instr_valid); end
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            miscompares++; $display("FAIL redir_flush_hold: req=%b instr=%b need 0/0", imem_req_valid, instr_valid);
        end
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
            miscompares++; $display("FAIL redir_resume: valid=%b addr=%h need 1/00000100", imem_req_valid, imem_req_addr);
        end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL redir_no_stale: got %b need 0", instr_valid); end
        expect_pc(32'h100);
        expect_pc(32'h104);
        grant(2);
        drain(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL redir_drain: %0d entries left, need 0", exp_q.size()); end
    endtask

    task automatic test_redirect_consume();
        mem_lat     = 2;
        instr_ready = 1'b0;
        expect_pc(32'h108);
        grant(3);
        repeat (3) tick();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #2;
        vectors++; if (instr_valid !== 1'b1 || instr_pc !== 32'h108) begin
            miscompares++; $display("FAIL rc_head: valid=%b pc=%h need 1/00000108", instr_valid, instr_pc);
        end
        vectors++; if (imem_rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rc_setup_rsp: got %b need 1", imem_rsp_valid); end
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #2;
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL rc_fifo_flushed: got %b need 0", instr_valid); end
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rc_flush_one: got %b need 0", imem_req_valid); end
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            miscompares++; $display("FAIL rc_resume: valid=%b addr=%h need 1/00000200", imem_req_valid, imem_req_addr);
        end
        expect_pc(32'h200);
        grant(1);
        drain(30, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rc_drain: %0d entries left, need 0", exp_q.size()); end
    endtask

    task automatic test_reset_flush();
        mem_lat     = 4;
        instr_ready = 1'b1;
        grant(3);
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rf_in_flush: got %b need 0", imem_req_valid); end
        reset = 1'b1;
        rsp_q.delete();
        imem_rsp_valid = 1'b0;
        mem_grant      = acc_cnt;
        imem_req_ready = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instruction !== 32'h0 || instr_pc !== 32'h0) begin
            miscompares++; $display("FAIL rf_async_outputs: req=%b iv=%b instr=%h pc=%h need all 0",
                                    imem_req_valid, instr_valid, instruction, instr_pc);
        end
        tick();
        tick();
        #2;
        vectors++; if (imem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rf_held_req: got %b need 0", imem_req_valid); end
        reset = 1'b0;
        #1;
        vectors++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            miscompares++; $display("FAIL rf_restart: valid=%b addr=%h need 1/00000000", imem_req_valid, imem_req_addr);
        end
        mem_lat = 1;
        expect_pc(32'h0);
        grant(1);
        drain(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rf_drain: %0d entries left, need 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_back_to_back();
        test_stall();
        test_redirect();
        test_redirect_consume();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the decode unit.
- Owns the program counter and issues word-aligned read requests to instruction memory.
- Buffers returned words in a small in-order prefetch FIFO and presents one instruction per cycle to decode through a valid/ready handshake.
- Supports a PC redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 4, prefetch FIFO entries and maximum outstanding requests (power of 2, >=2).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  ADDR_WIDTH  word-aligned fetch address.
- imem_rsp_valid  input  1  read data valid (in order, one per accepted request).
- imem_rsp_data  input  32  instruction word.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode consumes the head this cycle.
- instruction  output  32  FIFO head instruction word to decode.
- instr_pc  output  ADDR_WIDTH  address of the head instruction.
- redirect_valid  input  1  load a new PC and flush.
- redirect_pc  input  ADDR_WIDTH  redirect target; bits [1:0] ignored and treated as 0.

Behaviour:
- Reset (asynchronous, any time, including mid-fetch or mid-flush):
  - pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0, state=RUN.
  - imem_req_valid=0, instr_valid=0, instruction=0, instr_pc=0.
- Transfer rules:
  - A request transfer occurs when imem_req_valid && imem_req_ready. On a transfer: pc <= pc+4 (modulo 2^ADDR_WIDTH, wraps silently) and outstanding increments.
  - A consume occurs when instr_valid && instr_ready.
- Request issue:
  - imem_req_valid=1 only when state==RUN, no redirect_valid this cycle, and outstanding + fifo_count < FIFO_DEPTH. This credit rule guarantees the FIFO can never overflow.
  - A consume in the same cycle does NOT free a credit until the next cycle.
  - imem_req_addr = pc. Once valid is asserted, address and valid hold stable until accepted unless a redirect occurs.
- Response:
  - In RUN, each imem_rsp_valid pushes {pc_of_request, data} into the FIFO and decrements outstanding.
  - Request PCs are tracked in a FIFO_DEPTH-entry tag queue, or equivalently by a write pointer into the PC field reserved at issue time.
- Output:
  - instr_valid = FIFO not empty; instruction and instr_pc come from the FIFO head.
  - Push and pop may occur in the same cycle.
  - Minimum latency from request acceptance at cycle N with a response at N+1 is instr_valid at N+2 (registered FIFO).
- Redirect (redirect_valid=1, any state), effective next edge:
  - pc <= {redirect_pc[ADDR_WIDTH-1:2],2'b00}; FIFO flushed; any consume in that cycle is ignored for state purposes.
  - drop_cnt <= outstanding minus responses arriving this cycle; outstanding <= 0.
  - State <= FLUSH if that drop_cnt is non-zero, else RUN.
  - A request offered in the redirect cycle is not issued (imem_req_valid=0).
- FLUSH state:
  - No requests issued; instr_valid=0.
  - Each imem_rsp_valid is discarded and decrements drop_cnt. When drop_cnt reaches 0, go to RUN.
  - A further redirect in FLUSH overwrites pc and keeps counting down the remaining drops.
- Error rule: imem_rsp_valid with outstanding==0 and drop_cnt==0 is ignored (not pushed).

Test Plan:
- Reset then a memory with 1-cycle latency, imem_req_ready=1, instr_ready=1: requests at 0x0, 0x4, 0x8, ... → decode sees instr_pc 0x0, 0x4, 0x8 with matching words (0x20220005 at 0x0), one per cycle in steady state.
- Hold instr_ready=0: exactly 4 requests issued (0x0–0xC), then imem_req_valid=0; FIFO holds 4 entries. Release ready → all 4 delivered in order, then fetching resumes at 0x10.
- imem_req_ready=0 for 3 cycles with pc=0x8 → imem_req_addr stays 0x8 and valid stays 1; after acceptance, pc becomes 0xC.
- With 3 outstanding requests on a 3-cycle-latency memory, assert redirect_pc=0x103 → next address 0x100; the 3 stale responses are dropped (instr_valid stays 0); the first delivered instruction has instr_pc=0x100.
- Redirect in the same cycle as a consume and a response → FIFO empty next cycle, response counted as consumed, drop_cnt = outstanding-1.
- Assert reset mid-FLUSH with drop_cnt=2 → all outputs 0 immediately (asynchronously); after deassert, the first request is at RESET_PC.
